ifetch_unit: RTL and testbench

- Front end of the out-of-order core: owns the PC and fetches 32-bit instruction words from the memory controller over a request/done handshake.
- Generates the sign-extended immediate for each instruction.
- Presents one instruction per valid pulse to the decoder (ins, ins_flag, ins_imm, ins_pc).
- Honours the downstream stall (ROB/RS/LSB full) and redirects from the ROB on mispredict or JALR resolution. Static prediction: JAL taken, everything else PC+4.

---
 rtl/ifetch_unit_if.sv | 42 ++++
 rtl/ifetch_unit.sv | 164 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: memory-controller handshake plus the decoder-facing issue port.
interface ifetch_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  // Memory controller side
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [31:0]       mem_data;

  // Decoder side
  logic [31:0]       ins;
  logic              ins_flag;
  logic [31:0]       ins_imm;
  logic [ADDR_W-1:0] ins_pc;

  // Fetch unit drives requests and issued instructions
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_done,
    input  mem_data,
    output ins,
    output ins_flag,
    output ins_imm,
    output ins_pc
  );

  // Memory controller / decoder view
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_done,
    output mem_data,
    input  ins,
    input  ins_flag,
    input  ins_imm,
    input  ins_pc
  );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time from the memory
// controller, generates the immediate and issues one instruction per valid pulse.
// Static prediction: JAL taken, everything else falls through to pc+4.
module ifetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rdy_i,
  input  logic              stall_i,
  input  logic              br_flag_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  ifetch_unit_if.master     bus_io
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       hold_q, hold_d;
  logic [31:0]       ins_q, ins_d;
  logic              ins_flag_q, ins_flag_d;
  logic [31:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;

  logic              do_issue;
  logic [31:0]       issue_word;
  logic [31:0]       issue_imm;

  // Sign-extended immediate selected by the major opcode
  function automatic logic [31:0] gen_imm(input logic [31:0] w);
    logic [31:0] imm;
    unique case (w[6:0])
      OpLoad, OpJalr: imm = {{20{w[31]}}, w[31:20]};
      OpOpImm: begin
        // funct3 001/101 are shifts: shamt is unsigned and funct7 must not leak in
        if (w[13:12] == 2'b01) imm = {27'b0, w[24:20]};
        else                   imm = {{20{w[31]}}, w[31:20]};
      end
      OpStore:        imm = {{20{w[31]}}, w[31:25], w[11:7]};
      OpBranch:       imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OpLui, OpAuipc: imm = {w[31:12], 12'b0};
      OpJal:          imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:        imm = '0;
    endcase
    return imm;
  endfunction

  assign issue_imm = gen_imm(issue_word);

  // Next-state logic for the fetch FSM, PC and issue registers
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    hold_d     = hold_q;
    ins_d      = ins_q;
    imm_d      = imm_q;
    ins_pc_d   = ins_pc_q;
    ins_flag_d = 1'b0;
    do_issue   = 1'b0;
    issue_word = hold_q;

    unique case (state_q)
      StFetch: begin
        mem_req_d  = 1'b1;
        mem_addr_d = br_flag_i ? br_pc_i : pc_q;
        if (br_flag_i) pc_d = br_pc_i;
        state_d = StWait;
      end
      StWait: begin
        if (bus_io.mem_done) begin
          mem_req_d = 1'b0;
          if (discard_q || br_flag_i) begin
            // Stale word from before a redirect: drop it
            discard_d = 1'b0;
            if (br_flag_i) pc_d = br_pc_i;
            state_d = StFetch;
          end else if (!stall_i) begin
            do_issue   = 1'b1;
            issue_word = bus_io.mem_data;
            state_d    = StFetch;
          end else begin
            hold_d  = bus_io.mem_data;
            state_d = StHold;
          end
        end else if (br_flag_i) begin
          // Controller cannot abort: keep the request and throw the reply away later
          discard_d = 1'b1;
          pc_d      = br_pc_i;
        end
      end
      StHold: begin
        if (br_flag_i) begin
          pc_d    = br_pc_i;
          state_d = StFetch;
        end else if (!stall_i) begin
          do_issue = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    if (do_issue) begin
      ins_d      = issue_word;
      imm_d      = issue_imm;
      ins_pc_d   = pc_q;
      ins_flag_d = 1'b1;
      if (issue_word[6:0] == OpJal) pc_d = pc_q + ADDR_W'(issue_imm);
      else                          pc_d = pc_q + ADDR_W'(32'd4);
    end
  end

  // State registers; rdy low freezes everything including the issue pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      hold_q     <= '0;
      ins_q      <= '0;
      imm_q      <= '0;
      ins_pc_q   <= '0;
      ins_flag_q <= 1'b0;
    end else if (rdy_i) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      hold_q     <= hold_d;
      ins_q      <= ins_d;
      imm_q      <= imm_d;
      ins_pc_q   <= ins_pc_d;
      ins_flag_q <= ins_flag_d;
    end
  end

  assign bus_io.mem_req  = mem_req_q;
  assign bus_io.mem_addr = mem_addr_q;
  assign bus_io.ins      = ins_q;
  assign bus_io.ins_flag = ins_flag_q;
  assign bus_io.ins_imm  = imm_q;
  assign bus_io.ins_pc   = ins_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by randomized fetch traffic,
// checked against a PC/immediate reference model built from the instruction-set rules.
module tb_ifetch_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              rdy;
  logic              stall;
  logic              br_flag;
  logic [ADDR_W-1:0] br_pc;

  ifetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  ifetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rdy_i    (rdy),
    .stall_i  (stall),
    .br_flag_i(br_flag),
    .br_pc_i  (br_pc),
    .bus_io   (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  // Immediate from the instruction-format definitions, using integer arithmetic
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    int u;
    s = int'(w);
    u = int'(w);
    case (w[6:0])
      7'h03, 7'h67: return 32'(s >>> 20);
      7'h13: begin
        if (((u >> 12) & 3) == 1) return 32'((u >> 20) & 31);
        return 32'(s >>> 20);
      end
      7'h23: return 32'(((s >>> 25) << 5) | ((u >> 7) & 31));
      7'h63: return 32'(((s >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                        (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
      7'h37, 7'h17: return w & 32'hFFFF_F000;
      7'h6F: return 32'(((s >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                        (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
    if (w[6:0] == 7'h6F) return pc + ref_imm(w);
    return pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(bus.mem_req), 32'd1);
  endtask

  // Serve one fetch: lat idle cycles in WAIT, then done with stall held for stall_n cycles
  task automatic serve(input logic [31:0] word, input int lat, input int stall_n);
    wait_req();
    chk("mem_addr", bus.mem_addr, model_pc);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("req_held", 32'(bus.mem_req), 32'd1);
      chk("addr_stable", bus.mem_addr, model_pc);
    end
    stall         = (stall_n > 0);
    bus.mem_done  = 1'b1;
    bus.mem_data  = word;
    tick();
    bus.mem_done  = 1'b0;
    bus.mem_data  = $urandom;
    if (stall_n > 0) begin
      chk("no_flag_stalled", 32'(bus.ins_flag), 32'd0);
      for (int k = 1; k < stall_n; k++) begin
        tick();
        chk("no_flag_stalled", 32'(bus.ins_flag), 32'd0);
        chk("no_refetch", 32'(bus.mem_req), 32'd0);
      end
      stall = 1'b0;
      tick();
    end
    chk("ins_flag", 32'(bus.ins_flag), 32'd1);
    chk("ins", bus.ins, word);
    chk("ins_imm", bus.ins_imm, ref_imm(word));
    chk("ins_pc", bus.ins_pc, model_pc);
    model_pc = ref_next(model_pc, word);
    tick();
    chk("flag_single", 32'(bus.ins_flag), 32'd0);
  endtask

  logic [6:0] opcodes [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h37,
                               7'h63, 7'h67, 7'h6F, 7'h33, 7'h0F};

  initial begin
    logic [31:0] w;
    rst_n        = 1'b0;
    rdy          = 1'b1;
    stall        = 1'b0;
    br_flag      = 1'b0;
    br_pc        = '0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    model_pc     = 32'h0;
    #3;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_ins_flag", 32'(bus.ins_flag), 32'd0);
    chk("rst_ins", bus.ins, 32'h0);
    chk("rst_ins_imm", bus.ins_imm, 32'h0);
    chk("rst_ins_pc", bus.ins_pc, 32'h0);
    #9 rst_n = 1'b1;

    // Directed program: addi, nop, jal +8, stalled beq, lui, srai, sw
    serve(32'h0050_0093, 0, 0);
    serve(32'h0000_0013, 1, 0);
    serve(32'h0080_00EF, 2, 0);
    chk("jal_target", model_pc, 32'h10);
    serve(32'hFE00_0EE3, 1, 3);
    serve(32'h1234_5037, 0, 0);
    serve(32'h4050_5013, 0, 0);
    serve(32'h00A1_2223, 0, 0);

    // Redirect while WAIT: request held, reply dropped, refetch at br_pc
    wait_req();
    chk("mem_addr", bus.mem_addr, model_pc);
    tick();
    br_flag = 1'b1;
    br_pc   = 32'h100;
    tick();
    br_flag = 1'b0;
    chk("br_req_held", 32'(bus.mem_req), 32'd1);
    chk("br_no_flag", 32'(bus.ins_flag), 32'd0);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h0050_0093;
    tick();
    bus.mem_done = 1'b0;
    chk("br_drop_flag", 32'(bus.ins_flag), 32'd0);
    chk("br_req_drop", 32'(bus.mem_req), 32'd0);
    model_pc = 32'h100;
    serve(32'h0000_0013, 0, 0);

    // Redirect coincident with mem_done
    wait_req();
    chk("mem_addr", bus.mem_addr, model_pc);
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h0000_0013;
    br_flag      = 1'b1;
    br_pc        = 32'h200;
    tick();
    bus.mem_done = 1'b0;
    br_flag      = 1'b0;
    chk("brdone_no_flag", 32'(bus.ins_flag), 32'd0);
    model_pc = 32'h200;
    serve(32'h0010_0093, 1, 0);

    // Redirect while a stalled word sits in HOLD: word never issues
    wait_req();
    chk("mem_addr", bus.mem_addr, model_pc);
    stall        = 1'b1;
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h0000_0013;
    tick();
    bus.mem_done = 1'b0;
    chk("hold_no_flag", 32'(bus.ins_flag), 32'd0);
    stall   = 1'b0;
    br_flag = 1'b1;
    br_pc   = 32'h300;
    tick();
    br_flag = 1'b0;
    chk("hold_br_no_flag", 32'(bus.ins_flag), 32'd0);
    tick();
    chk("hold_br_no_flag2", 32'(bus.ins_flag), 32'd0);
    model_pc = 32'h300;
    serve(32'h0020_0093, 0, 0);

    // rdy low for 5 cycles during WAIT: done pulse ignored, nothing moves
    wait_req();
    chk("mem_addr", bus.mem_addr, model_pc);
    rdy = 1'b0;
    tick();
    tick();
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h0000_0013;
    tick();
    bus.mem_done = 1'b0;
    tick();
    tick();
    chk("rdy_req_held", 32'(bus.mem_req), 32'd1);
    chk("rdy_addr", bus.mem_addr, model_pc);
    chk("rdy_no_flag", 32'(bus.ins_flag), 32'd0);
    rdy = 1'b1;
    serve(32'h0030_0093, 0, 0);

    // Randomized traffic: random opcodes, latencies and stall lengths
    for (int it = 0; it < 40; it++) begin
      w = $urandom;
      w[6:0] = opcodes[$urandom_range(0, 9)];
      serve(w, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a request
    wait_req();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_addr", bus.mem_addr, 32'h0);
    chk("midrst_flag", 32'(bus.ins_flag), 32'd0);
    chk("midrst_ins", bus.ins, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = 32'h0;
    serve(32'h0050_0093, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
